smc_arb_lite18: RTL



---
 rtl/smc_arb_lite18.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/smc_arb_lite18.sv
// Round-robin scheduler that lends the SMC state machine to one requester per burst.
// The grant is held from arbitration until the SMC reports idle, followed by a one-cycle ack.
module smc_arb_lite18 #(
  parameter int NUM_REQ = 3,
  parameter int BEAT_W  = 4
) (
  input  logic                      sys_clk18,
  input  logic                      sys_reset18,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*BEAT_W-1:0] beats_i,
  input  logic [NUM_REQ-1:0]        n_read_i,
  input  logic [NUM_REQ-1:0]        cs_i,
  input  logic                      smc_valid_access,
  input  logic                      smc_idle,
  output logic                      smc_new_access,
  output logic                      smc_mac_done,
  output logic                      smc_n_read,
  output logic                      smc_cs,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ACTIVE, S_DRAIN, S_DONE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_ptr_q, win_q, win_d, win_hi, win_lo;
  logic [BEAT_W-1:0]  rem_q, beats_d;
  logic               n_read_d, cs_d, found_hi, found_lo;
  logic               new_access_q, mac_done_q, n_read_q, cs_q, busy_q;
  logic [NUM_REQ-1:0] grant_q, ack_q;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    for (int i = 0; i < NUM_REQ; i++) oh[i] = (IDX_W'(i) == idx);
    return oh;
  endfunction

  // Winner is the lowest requester at or above rr_ptr, else the lowest overall (wrap).
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = IDX_W'(i);
      end
      if (req_i[i] && !found_hi && (IDX_W'(i) >= rr_ptr_q)) begin
        found_hi = 1'b1;
        win_hi   = IDX_W'(i);
      end
    end
    win_d    = found_hi ? win_hi : win_lo;
    beats_d  = '0;
    n_read_d = 1'b1;
    cs_d     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win_d) begin
        beats_d  = beats_i[i*BEAT_W +: BEAT_W];
        n_read_d = n_read_i[i];
        cs_d     = cs_i[i];
      end
    end
    if (beats_d == '0) beats_d = BEAT_W'(1);
  end

  always_ff @(posedge sys_clk18) begin
    if (sys_reset18) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      new_access_q <= 1'b0;
      mac_done_q   <= 1'b0;
      n_read_q     <= 1'b1;
      cs_q         <= 1'b0;
      grant_q      <= '0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req_i) begin
            state_q  <= S_GRANT;
            busy_q   <= 1'b1;
            win_q    <= win_d;
            rem_q    <= beats_d;
            n_read_q <= n_read_d;
            cs_q     <= cs_d;
            grant_q  <= onehot(win_d);
          end
        end
        S_GRANT: begin
          state_q      <= S_ACTIVE;
          new_access_q <= 1'b1;
          mac_done_q   <= (rem_q == BEAT_W'(1));
        end
        S_ACTIVE: begin
          if (smc_valid_access && (rem_q != '0)) begin
            rem_q <= rem_q - BEAT_W'(1);
            if (rem_q == BEAT_W'(1)) begin
              state_q      <= S_DRAIN;
              new_access_q <= 1'b0;
              mac_done_q   <= 1'b1;
            end else begin
              mac_done_q   <= (rem_q == BEAT_W'(2));
            end
          end
        end
        // SMC must be back in IDLE before the grant is released.
        S_DRAIN: begin
          if (smc_idle) begin
            state_q    <= S_DONE;
            mac_done_q <= 1'b0;
            n_read_q   <= 1'b1;
            cs_q       <= 1'b0;
            grant_q    <= '0;
            ack_q      <= onehot(win_q);
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          ack_q    <= '0;
          rr_ptr_q <= (win_q == IDX_W'(NUM_REQ-1)) ? '0 : win_q + IDX_W'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign smc_new_access = new_access_q;
  assign smc_mac_done   = mac_done_q;
  assign smc_n_read     = n_read_q;
  assign smc_cs         = cs_q;
  assign grant_o        = grant_q;
  assign ack_o          = ack_q;
  assign busy           = busy_q;

endmodule
